// File: rtl/bit_deserializer.sv
// Serial-to-parallel receiver: packs qualified MSB-first bits into [f:k] words
// and presents each word on a one-entry valid/ready output buffer.
module bit_deserializer #(
   parameter int f = 7,
   parameter int k = 0
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         sin,
   input  logic         sin_valid,
   input  logic         sof,
   output logic [f:k]   dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         overflow,
   input  logic         clr_ovf,
   output logic         busy
);

   localparam int unsigned W  = f - k + 1;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   logic [W-1:0]  shift_q;
   logic [W-1:0]  shift_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          complete_c;
   logic          accept_c;
   logic          load_c;
   logic          drop_c;

   // Next shift/count state and the output-buffer decision for this cycle
   always_comb begin
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      complete_c = 1'b0;
      if (sin_valid) begin
         if (sof) begin
            shift_d    = W'(sin);
            complete_c = (W == 1);
            cnt_d      = (W == 1) ? '0 : CW'(1);
         end else begin
            shift_d    = (shift_q << 1) | W'(sin);
            complete_c = (cnt_q == CW'(W - 1));
            cnt_d      = complete_c ? '0 : cnt_q + CW'(1);
         end
      end
      accept_c = dout_valid & dout_ready;
      load_c   = complete_c & (~dout_valid | dout_ready);
      drop_c   = complete_c & ~load_c;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         shift_q    <= '0;
         cnt_q      <= '0;
         busy       <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         busy    <= (cnt_d != '0);
         if (load_c) begin
            dout       <= shift_d;
            dout_valid <= 1'b1;
         end else if (accept_c) begin
            dout_valid <= 1'b0;
         end
         // A drop in the same cycle as a clear keeps the flag set
         if (drop_c)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: an 8-bit and a 1-bit instance share stimulus and
// are compared every cycle against a word-level model, plus fixed vectors.
module tb_bit_deserializer;

   logic       clk = 1'b0;
   logic       rstn, sin, sin_valid, sof, dout_ready, clr_ovf;
   logic [7:0] dout8;
   logic [0:0] dout1;
   logic       valid8, valid1, ovf8, ovf1, busy8, busy1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bit_deserializer #(.f(7), .k(0)) dut8 (
      .clk(clk), .rstn(rstn), .sin(sin), .sin_valid(sin_valid), .sof(sof),
      .dout(dout8), .dout_valid(valid8), .dout_ready(dout_ready),
      .overflow(ovf8), .clr_ovf(clr_ovf), .busy(busy8));

   bit_deserializer #(.f(0), .k(0)) dut1 (
      .clk(clk), .rstn(rstn), .sin(sin), .sin_valid(sin_valid), .sof(sof),
      .dout(dout1), .dout_valid(valid1), .dout_ready(dout_ready),
      .overflow(ovf1), .clr_ovf(clr_ovf), .busy(busy1));

   typedef struct {
      int pw;
      int n;
      int data;
      bit valid;
      bit ovf;
   } mstate_t;

   mstate_t m8, m1;

   // Word-level reference: partial word value and bit count, one-entry buffer
   function automatic mstate_t mstep(mstate_t s, int w, bit rst, bit sv, bit sf,
                                     bit si, bit rdy, bit clr);
      mstate_t r    = s;
      bit      done = 0;
      bit      acc  = s.valid && rdy;
      bit      setv;
      int      word = 0;
      if (rst) begin
         r.pw = 0; r.n = 0; r.data = 0; r.valid = 0; r.ovf = 0;
         return r;
      end
      if (sv) begin
         if (sf) begin
            r.pw = si; r.n = 1;
         end else begin
            r.pw = (s.pw * 2 + si) % (1 << w); r.n = s.n + 1;
         end
         if (r.n == w) begin
            done = 1; word = r.pw; r.n = 0;
         end
      end
      setv = done && s.valid && !acc;
      if (done && !setv) begin
         r.data = word; r.valid = 1;
      end else if (acc) begin
         r.valid = 0;
      end
      r.ovf = setv ? 1'b1 : (clr ? 1'b0 : s.ovf);
      return r;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare both instances
   task automatic step(input bit rst, input bit sv, input bit sf, input bit si,
                       input bit rdy, input bit clr);
      rstn = !rst; sin_valid = sv; sof = sf; sin = si; dout_ready = rdy; clr_ovf = clr;
      m8 = mstep(m8, 8, rst, sv, sf, si, rdy, clr);
      m1 = mstep(m1, 1, rst, sv, sf, si, rdy, clr);
      @(posedge clk); #1;
      check("m8_dout",  int'(dout8),  m8.data);
      check("m8_valid", int'(valid8), int'(m8.valid));
      check("m8_ovf",   int'(ovf8),   int'(m8.ovf));
      check("m8_busy",  int'(busy8),  int'(m8.n != 0));
      check("m1_dout",  int'(dout1),  m1.data);
      check("m1_valid", int'(valid1), int'(m1.valid));
      check("m1_ovf",   int'(ovf1),   int'(m1.ovf));
      check("m1_busy",  int'(busy1),  0);
   endtask

   task automatic send_word(input logic [7:0] val, input bit first_sof,
                            input bit rdy_rest, input bit rdy_last, input bit clr_last);
      for (int i = 7; i >= 0; i--)
         step(0, 1, (i == 7) && first_sof, val[i], (i == 0) ? rdy_last : rdy_rest,
              (i == 0) ? clr_last : 1'b0);
   endtask

   typedef struct {
      bit rst, sv, sf, si, rdy, clr;
      int ed;
      bit ev, eo, eb;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit rst, bit sv, bit sf, bit si, bit rdy, bit clr,
                               int ed, bit ev, bit eo, bit eb);
      vec_t v;
      v.rst = rst; v.sv = sv; v.sf = sf; v.si = si; v.rdy = rdy; v.clr = clr;
      v.ed = ed; v.ev = ev; v.eo = eo; v.eb = eb;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [7:0] gap;
      rstn = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; dout_ready = 1'b0; clr_ovf = 1'b0;
      m8 = '{default: 0};
      m1 = '{default: 0};

      // Reset, then 0xA5 with ready low, then accept
      add(1, 0, 0, 0, 0, 0, 'h00, 0, 0, 0);
      add(0, 1, 1, 1, 0, 0, 'h00, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 'h00, 0, 0, 1);
      add(0, 1, 0, 1, 0, 0, 'h00, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 'h00, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 'h00, 0, 0, 1);
      add(0, 1, 0, 1, 0, 0, 'h00, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 'h00, 0, 0, 1);
      add(0, 1, 0, 1, 0, 0, 'hA5, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0, 'hA5, 0, 0, 0);
      // 0x3C with an idle cycle after every bit
      gap = 8'h3C;
      for (int i = 7; i >= 1; i--) begin
         add(0, 1, i == 7, gap[i], 0, 0, 'hA5, 0, 0, 1);
         add(0, 0, 1, ~gap[i], 0, 0, 'hA5, 0, 0, 1);
      end
      add(0, 1, 0, gap[0], 0, 0, 'h3C, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 'h3C, 1, 0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].sv, tbl[i].sf, tbl[i].si, tbl[i].rdy, tbl[i].clr);
         check($sformatf("vec%0d_dout", i),  int'(dout8),  tbl[i].ed);
         check($sformatf("vec%0d_valid", i), int'(valid8), int'(tbl[i].ev));
         check($sformatf("vec%0d_ovf", i),   int'(ovf8),   int'(tbl[i].eo));
         check($sformatf("vec%0d_busy", i),  int'(busy8),  int'(tbl[i].eb));
      end

      // Back-to-back: 0x7E completes in the cycle 0x81 is accepted
      step(0, 0, 0, 0, 1, 0);
      send_word(8'h81, 1, 0, 0, 0);
      check("b2b_first", int'(dout8), 'h81);
      send_word(8'h7E, 1, 0, 1, 0);
      check("b2b_second", int'(dout8), 'h7E);
      check("b2b_valid", int'(valid8), 1);
      check("b2b_ovf", int'(ovf8), 0);
      step(0, 0, 0, 0, 1, 0);
      check("b2b_drain", int'(valid8), 0);

      // Overflow: drop, then drop coinciding with clear, then clear alone
      send_word(8'h11, 1, 0, 0, 0);
      send_word(8'h22, 1, 0, 0, 0);
      check("ovf_hold_dout", int'(dout8), 'h11);
      check("ovf_set", int'(ovf8), 1);
      send_word(8'h33, 1, 0, 0, 1);
      check("ovf_set_wins", int'(ovf8), 1);
      check("ovf_dout_kept", int'(dout8), 'h11);
      step(0, 0, 0, 0, 0, 1);
      check("ovf_clear", int'(ovf8), 0);
      check("ovf_valid_kept", int'(valid8), 1);

      // Resync: 5 garbage bits, then a fresh word with sof
      step(0, 0, 0, 0, 1, 0);
      step(0, 1, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check("resync_busy", int'(busy8), 1);
      send_word(8'hC3, 1, 0, 0, 0);
      check("resync_dout", int'(dout8), 'hC3);
      check("resync_ovf", int'(ovf8), 0);

      // Reset mid-word drops the pending word; next 8 bits form a word
      step(0, 1, 1, 1, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 1, 1);
      check("rst_dout", int'(dout8), 0);
      check("rst_valid", int'(valid8), 0);
      check("rst_busy", int'(busy8), 0);
      check("rst_ovf", int'(ovf8), 0);
      send_word(8'h5A, 0, 0, 0, 0);
      check("post_rst_word", int'(dout8), 'h5A);

      // Single-bit words
      step(0, 1, 0, 1, 1, 0);
      check("w1_one", int'(dout1), 1);
      check("w1_valid", int'(valid1), 1);
      step(0, 1, 1, 0, 1, 0);
      check("w1_sof_zero", int'(dout1), 0);
      check("w1_sof_valid", int'(valid1), 1);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++)
         step($urandom_range(0, 255) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom),
              $urandom_range(0, 7) == 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bit_deserializer.md
Name: bit_deserializer

Overview:
Serial-to-parallel receiver. It is the expanding counterpart of the bus-reducing submodule.
- Collects a qualified serial bit stream, MSB first, into [f:k]-wide words.
- Presents each completed word on a one-entry output buffer with a valid/ready handshake.
- Sits between a single-bit link and word-oriented logic; intended for TMRG triplication like other blocks in this design.

Parameters:
f, 7, MSB index of the output word
k, 0, LSB index of the output word; word width W = f-k+1 (localparam), requires f >= k

Ports:
clk  input  1  system clock; all logic on rising edge
rstn  input  1  synchronous active-low reset
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled this cycle when high
sof  input  1  start of frame; qualified by sin_valid; marks sin as the first (MSB) bit of a word
dout  output  [f:k]  parallel word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready
overflow  output  1  sticky: a completed word was dropped
clr_ovf  input  1  clears overflow
busy  output  1  partial word in progress (bit counter != 0)

Behaviour:
- Reset: one clk edge with rstn=0 forces:
  - dout=0, dout_valid=0, overflow=0, busy=0
  - shift register=0, bit counter cnt=0
  - Reset has priority over every other input, including mid-word and while dout_valid=1; the pending word is lost.
- Bit counter cnt:
  - Range 0..W-1; width $clog2(W), minimum 1.
  - busy = (cnt != 0).
- Sampling: only on sin_valid=1. Cycles with sin_valid=0 change nothing in the shift path; sof is ignored when sin_valid=0.
- Shift order: MSB first. The first bit of a word ends up in dout[f]; the last bit ends up in dout[k].
- Append (sin_valid=1, sof=0): shift = {shift[W-2:0], sin}; cnt advances.
- Resync (sin_valid=1, sof=1): any partial word is discarded without setting overflow; this bit becomes bit 0 of a new word (cnt=1).
- Word completion: the sampled bit is bit index W-1 of the current word.
  - Append with cnt=W-1, or sof with W=1.
  - cnt wraps to 0.
- Load rule on completion:
  - If dout_valid=0, or dout_valid & dout_ready in the same cycle: dout <= completed word and dout_valid <= 1 at that edge. Latency is 1 cycle from the last bit sample to dout_valid.
  - Otherwise the word is dropped, overflow <= 1, and dout is unchanged.
- Handshake:
  - dout_valid & dout_ready with no completion that cycle: dout_valid <= 0; dout retains its value.
  - dout is stable while dout_valid=1 and dout_ready=0.
  - Back-to-back: completion with a simultaneous accept keeps dout_valid=1 with the new word; no bubble.
- overflow:
  - Set on a dropped word.
  - Cleared by clr_ovf=1.
  - If set and clear coincide, set wins (overflow=1).
- Throughput: one bit per cycle sustained, i.e. one word per W cycles, with no stall of the serial side. The serial side has no backpressure; loss is reported only via overflow.
- W=1: every valid bit is a complete word; busy stays 0.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-word: feed 3 bits, then rstn=0 for 1 cycle → dout=0x00, dout_valid=0, busy=0, overflow=0; the next 8 bits form a fresh word.
- Basic word: sof+1,0,1,0,0,1,0,1 on consecutive cycles, dout_ready=0 → dout=0xA5, dout_valid=1 exactly 1 cycle after the 8th bit; busy high after bits 1-7 and low after the 8th.
- Gapped input: bits of 0x3C with sin_valid toggling 1/0 → dout=0x3C; idle cycles change neither cnt nor shift.
- Back-to-back with ready=1: 0x81 then 0x7E with no gap → dout_valid stays 1 across the boundary, dout goes 0x81 → 0x7E, each accepted once, overflow=0.
- Overflow: dout_ready=0, send 0x11 then 0x22 → dout stays 0x11 and overflow=1; then clr_ovf=1 in the same cycle as another drop → overflow stays 1; clr_ovf alone → 0.
- Resync: 5 bits of garbage, then sof+bits of 0xC3 → dout=0xC3, overflow=0; f=0,k=0 instance: each valid bit yields dout_valid with dout=sin.
